// File: rtl/ikbd_pkg.sv
// Shared types and helpers for the IKBD relative-mouse packetizer.
package ikbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DX, ST_DY} state_t;

  localparam logic [7:0] MOUSE_REL_HDR = 8'hF8;

  // Position in the 00->10->11->01 cycle, so a +1 step is a +1 position change.
  function automatic logic [1:0] quad_pos(input logic [1:0] q);
    case (q)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                input logic signed [1:0] s);
    logic signed [8:0] sum;
    sum = {a[7], a} + {{7{s[1]}}, s};
    if (sum > 9'sd127)       return 8'sd127;
    else if (sum < -9'sd128) return -8'sd128;
    else                     return sum[7:0];
  endfunction
endpackage

// File: rtl/ikbd_quad_dec.sv
// One quadrature axis: previous-state register, -1/0/+1 step and illegal-jump flag.
module ikbd_quad_dec
  import ikbd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        quad,
  output logic signed [1:0] step,
  output logic              err
);
  logic [1:0] prev;
  logic [1:0] diff;

  // prev always follows the input; en only gates whether the change counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 2'b00;
    else       prev <= quad;
  end

  always_comb begin
    diff = quad_pos(quad) - quad_pos(prev);
    step = 2'sd0;
    err  = 1'b0;
    if (en) begin
      case (diff)
        2'd1:    step = 2'sd1;
        2'd3:    step = -2'sd1;
        2'd2:    err  = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ikbd_mouse.sv
// Atari mouse port to IKBD relative-report packets (header, dx, dy).
module ikbd_mouse
  import ikbd_pkg::*;
#(
  parameter int THRESH_X = 1,
  parameter int THRESH_Y = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] mouse_atari,
  input  logic       report_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       quad_err
);
  logic [5:0]        sync1, sync2;
  logic [2:0]        vld_pipe;
  logic signed [1:0] step_x, step_y;
  logic              err_x, err_y;
  logic signed [7:0] dx, dy;
  logic [7:0]        hdr_snap, dx_snap, dy_snap;
  logic [1:0]        last_btn, btn;
  state_t            state;
  logic              trig, over_x, over_y, accept;

  // vld_pipe[2] rises one cycle after sync2 first holds a real pin value,
  // so that first value only seeds the decoders' previous state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      vld_pipe <= '0;
    end else begin
      sync1    <= mouse_atari;
      sync2    <= sync1;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  ikbd_quad_dec u_dec_x (.clk(clk), .reset(reset), .en(vld_pipe[2]),
                         .quad(sync2[1:0]), .step(step_x), .err(err_x));
  ikbd_quad_dec u_dec_y (.clk(clk), .reset(reset), .en(vld_pipe[2]),
                         .quad(sync2[3:2]), .step(step_y), .err(err_y));

  assign btn    = {sync2[4], sync2[5]};
  assign over_x = (int'(dx) >= THRESH_X) || (int'(dx) <= -THRESH_X);
  assign over_y = (int'(dy) >= THRESH_Y) || (int'(dy) <= -THRESH_Y);
  assign trig   = (state == ST_IDLE) && report_en && (over_x || over_y || (btn != last_btn));
  assign accept = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx       <= '0;
      dy       <= '0;
      hdr_snap <= '0;
      dx_snap  <= '0;
      dy_snap  <= '0;
      last_btn <= '0;
      quad_err <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      quad_err <= err_x | err_y;
      if (!report_en) begin
        dx <= '0;
        dy <= '0;
      end else if (trig) begin
        hdr_snap <= MOUSE_REL_HDR | {6'b0, btn};
        dx_snap  <= dx;
        dy_snap  <= dy;
        last_btn <= btn;
        dx       <= 8'(step_x);
        dy       <= 8'(step_y);
      end else begin
        dx <= sat_add(dx, step_x);
        dy <= sat_add(dy, step_y);
      end
      case (state)
        ST_IDLE: if (trig)   state <= ST_HDR;
        ST_HDR:  if (accept) state <= ST_DX;
        ST_DX:   if (accept) state <= ST_DY;
        default: if (accept) state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state != ST_IDLE);

  always_comb begin
    case (state)
      ST_HDR:  out_data = hdr_snap;
      ST_DX:   out_data = dx_snap;
      ST_DY:   out_data = dy_snap;
      default: out_data = 8'h00;
    endcase
  end
endmodule
